// File: rtl/ibex_ifetch_arbiter_if.sv
// Bus bundle between the fetch requesters / instruction memory and the
// ifetch arbiter. The arbiter uses the slave modport; the environment
// (requesters plus memory) uses the master modport.
interface ibex_ifetch_arbiter_if;
   logic [1:0]        req_i;
   logic [1:0][31:0]  addr_i;
   logic [1:0]        gnt_o;
   logic [1:0]        rvalid_o;
   logic [31:0]       rdata_o;
   logic              err_o;
   logic              instr_req_o;
   logic [31:0]       instr_addr_o;
   logic              instr_gnt_i;
   logic              instr_rvalid_i;
   logic [31:0]       instr_rdata_i;
   logic              instr_err_i;
   logic              spurious_rvalid_o;
   logic              busy_o;

   modport slave (
      input  req_i, addr_i, instr_gnt_i, instr_rvalid_i, instr_rdata_i, instr_err_i,
      output gnt_o, rvalid_o, rdata_o, err_o, instr_req_o, instr_addr_o,
             spurious_rvalid_o, busy_o
   );

   modport master (
      output req_i, addr_i, instr_gnt_i, instr_rvalid_i, instr_rdata_i, instr_err_i,
      input  gnt_o, rvalid_o, rdata_o, err_o, instr_req_o, instr_addr_o,
             spurious_rvalid_o, busy_o
   );
endinterface

// File: rtl/ibex_ifetch_arbiter.sv
// Round-robin arbiter sharing the instruction-memory bus between the
// prefetch buffer (port 0) and a secondary fetch requester (port 1).
// The address phase is locked while memory stalls the grant, and an
// owner FIFO routes in-order responses back to the issuing port.
module ibex_ifetch_arbiter #(
   parameter int unsigned MaxOutstanding = 2
) (
   input logic                   clk_i,
   input logic                   rst_i,
   ibex_ifetch_arbiter_if.slave  bus
);

   localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
   localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

   typedef enum logic {
      ARB  = 1'b0,
      HOLD = 1'b1
   } state_e;

   state_e                    state_q, state_d;
   logic                      hold_owner_q, hold_owner_d;
   logic                      rr_q;
   logic [CntW-1:0]           count_q;
   logic [PtrW-1:0]           wptr_q, rptr_q;
   logic [MaxOutstanding-1:0] owner_q;

   logic                      winner;
   logic                      issue_ok;
   logic                      instr_req;
   logic                      push;
   logic                      pop;
   logic                      head_owner;
   logic [1:0]                gnt;
   logic [1:0]                rvalid;
   logic                      spurious;
   logic                      busy;
   logic [31:0]               instr_addr;

   // Wrap a FIFO pointer modulo the number of owner slots.
   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      if (p == PtrW'(MaxOutstanding - 1)) begin
         return '0;
      end
      return p + PtrW'(1);
   endfunction

   // Address-phase state register.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= ARB;
         hold_owner_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         hold_owner_q <= hold_owner_d;
      end
   end

   // Winner selection, issue gating, response routing and next state.
   always_comb begin
      state_d      = state_q;
      hold_owner_d = hold_owner_q;
      winner       = rr_q;
      gnt          = 2'b00;
      rvalid       = 2'b00;

      if (state_q == HOLD) begin
         winner = hold_owner_q;
      end else if (bus.req_i[0] ^ bus.req_i[1]) begin
         winner = bus.req_i[1];
      end

      // Issue depends only on the registered count, never on instr_rvalid_i.
      issue_ok   = (count_q < CntW'(MaxOutstanding));
      instr_req  = !rst_i && issue_ok && bus.req_i[winner];
      instr_addr = rst_i ? 32'h0 : bus.addr_i[winner];
      push       = instr_req && bus.instr_gnt_i;
      gnt[winner] = push;

      head_owner     = owner_q[rptr_q];
      pop            = !rst_i && bus.instr_rvalid_i && (count_q != '0);
      spurious       = !rst_i && bus.instr_rvalid_i && (count_q == '0);
      rvalid[head_owner] = pop;

      busy = !rst_i && ((count_q != '0) || (state_q == HOLD));

      case (state_q)
         ARB: begin
            if (instr_req && !bus.instr_gnt_i) begin
               state_d      = HOLD;
               hold_owner_d = winner;
            end
         end
         HOLD: begin
            if (bus.instr_gnt_i) begin
               state_d = ARB;
            end
         end
         default: state_d = ARB;
      endcase
   end

   // Owner FIFO, outstanding count and round-robin pointer.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rr_q    <= 1'b0;
         count_q <= '0;
         wptr_q  <= '0;
         rptr_q  <= '0;
         owner_q <= '0;
      end else begin
         if (push) begin
            owner_q[wptr_q] <= winner;
            wptr_q          <= ptr_inc(wptr_q);
            rr_q            <= ~winner;
         end
         if (pop) begin
            rptr_q <= ptr_inc(rptr_q);
         end
         case ({push, pop})
            2'b10:   count_q <= count_q + CntW'(1);
            2'b01:   count_q <= count_q - CntW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   assign bus.gnt_o             = gnt;
   assign bus.rvalid_o          = rvalid;
   assign bus.rdata_o           = bus.instr_rdata_i;
   assign bus.err_o             = bus.instr_err_i;
   assign bus.instr_req_o       = instr_req;
   assign bus.instr_addr_o      = instr_addr;
   assign bus.spurious_rvalid_o = spurious;
   assign bus.busy_o            = busy;

endmodule

// File: tb/tb_ibex_ifetch_arbiter.sv
// Directed bench for ibex_ifetch_arbiter: streaming, contention, hold lock,
// outstanding limit, error/spurious responses and reset mid-operation.
module tb_ibex_ifetch_arbiter;

   logic clk;
   logic rst;
   int   total;
   int   bad;

   ibex_ifetch_arbiter_if bus ();

   ibex_ifetch_arbiter #(.MaxOutstanding(2)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // Apply inputs just after a rising edge, then let them settle.
   task automatic drive(input logic [1:0] req, input logic [31:0] a0, input logic [31:0] a1,
                        input logic gnt, input logic rv, input logic [31:0] rd, input logic er);
      bus.req_i          = req;
      bus.addr_i[0]      = a0;
      bus.addr_i[1]      = a1;
      bus.instr_gnt_i    = gnt;
      bus.instr_rvalid_i = rv;
      bus.instr_rdata_i  = rd;
      bus.instr_err_i    = er;
      #2;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst   = 1'b1;
      drive(2'b11, 32'h200, 32'h800, 1'b1, 1'b1, 32'h5, 1'b0);
      // Outputs forced low while in reset
      chk("rst_instr_req", 32'(bus.instr_req_o), 32'h0);
      chk("rst_gnt", 32'(bus.gnt_o), 32'h0);
      chk("rst_rvalid", 32'(bus.rvalid_o), 32'h0);
      chk("rst_spurious", 32'(bus.spurious_rvalid_o), 32'h0);
      chk("rst_busy", 32'(bus.busy_o), 32'h0);
      tick();
      tick();
      rst = 1'b0;
      drive(2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
      chk("idle_busy", 32'(bus.busy_o), 32'h0);
      chk("idle_req", 32'(bus.instr_req_o), 32'h0);

      // Single port stream
      drive(2'b01, 32'h100, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
      chk("s0_req", 32'(bus.instr_req_o), 32'h1);
      chk("s0_addr", bus.instr_addr_o, 32'h100);
      chk("s0_gnt", 32'(bus.gnt_o), 32'h1);
      tick();
      drive(2'b01, 32'h104, 32'h0, 1'b1, 1'b1, 32'hA, 1'b0);
      chk("s1_addr", bus.instr_addr_o, 32'h104);
      chk("s1_gnt", 32'(bus.gnt_o), 32'h1);
      chk("s1_rvalid", 32'(bus.rvalid_o), 32'h1);
      chk("s1_rdata", bus.rdata_o, 32'hA);
      tick();
      drive(2'b01, 32'h108, 32'h0, 1'b1, 1'b1, 32'hB, 1'b0);
      chk("s2_addr", bus.instr_addr_o, 32'h108);
      chk("s2_rvalid", 32'(bus.rvalid_o), 32'h1);
      chk("s2_rdata", bus.rdata_o, 32'hB);
      tick();
      drive(2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 32'hC, 1'b0);
      chk("s3_rvalid", 32'(bus.rvalid_o), 32'h1);
      chk("s3_rdata", bus.rdata_o, 32'hC);
      chk("s3_req", 32'(bus.instr_req_o), 32'h0);
      tick();
      drive(2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
      chk("s4_busy", 32'(bus.busy_o), 32'h0);

      // Reset returns the round-robin pointer to port 0
      rst = 1'b1;
      tick();
      rst = 1'b0;

      // Contention: grants alternate p0,p1,p0,p1 and responses follow owners
      drive(2'b11, 32'h200, 32'h800, 1'b1, 1'b0, 32'h0, 1'b0);
      chk("c0_gnt", 32'(bus.gnt_o), 32'h1);
      chk("c0_addr", bus.instr_addr_o, 32'h200);
      tick();
      drive(2'b11, 32'h200, 32'h800, 1'b1, 1'b1, 32'h11, 1'b0);
      chk("c1_gnt", 32'(bus.gnt_o), 32'h2);
      chk("c1_addr", bus.instr_addr_o, 32'h800);
      chk("c1_rvalid", 32'(bus.rvalid_o), 32'h1);
      tick();
      drive(2'b11, 32'h200, 32'h800, 1'b1, 1'b1, 32'h22, 1'b0);
      chk("c2_gnt", 32'(bus.gnt_o), 32'h1);
      chk("c2_rvalid", 32'(bus.rvalid_o), 32'h2);
      chk("c2_rdata", bus.rdata_o, 32'h22);
      tick();
      drive(2'b11, 32'h200, 32'h800, 1'b1, 1'b1, 32'h33, 1'b0);
      chk("c3_gnt", 32'(bus.gnt_o), 32'h2);
      chk("c3_rvalid", 32'(bus.rvalid_o), 32'h1);
      tick();
      drive(2'b00, 32'h200, 32'h800, 1'b0, 1'b1, 32'h44, 1'b0);
      chk("c4_rvalid", 32'(bus.rvalid_o), 32'h2);
      tick();
      drive(2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
      chk("c5_busy", 32'(bus.busy_o), 32'h0);

      // Hold lock: memory stalls 3 cycles, address stays on port 0
      for (int i = 0; i < 3; i++) begin
         drive(2'b11, 32'h200, 32'h800, 1'b0, 1'b0, 32'h0, 1'b0);
         chk("h_addr", bus.instr_addr_o, 32'h200);
         chk("h_gnt", 32'(bus.gnt_o), 32'h0);
         chk("h_req", 32'(bus.instr_req_o), 32'h1);
         tick();
      end
      chk("h_busy", 32'(bus.busy_o), 32'h1);
      drive(2'b11, 32'h200, 32'h800, 1'b1, 1'b0, 32'h0, 1'b0);
      chk("h_rel_addr", bus.instr_addr_o, 32'h200);
      chk("h_rel_gnt", 32'(bus.gnt_o), 32'h1);
      tick();
      drive(2'b11, 32'h200, 32'h800, 1'b1, 1'b0, 32'h0, 1'b0);
      chk("h_p1_addr", bus.instr_addr_o, 32'h800);
      chk("h_p1_gnt", 32'(bus.gnt_o), 32'h2);
      tick();
      // Two outstanding: issue blocked even while a response returns
      drive(2'b11, 32'h200, 32'h800, 1'b1, 1'b1, 32'h55, 1'b0);
      chk("h_blk_req", 32'(bus.instr_req_o), 32'h0);
      chk("h_blk_gnt", 32'(bus.gnt_o), 32'h0);
      chk("h_blk_rvalid", 32'(bus.rvalid_o), 32'h1);
      tick();
      drive(2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 32'h66, 1'b0);
      chk("h_last_rvalid", 32'(bus.rvalid_o), 32'h2);
      tick();
      drive(2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
      chk("h_idle_busy", 32'(bus.busy_o), 32'h0);

      // Outstanding limit: responses delayed, third request waits
      drive(2'b01, 32'h300, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
      chk("o0_req", 32'(bus.instr_req_o), 32'h1);
      tick();
      drive(2'b01, 32'h304, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
      chk("o1_req", 32'(bus.instr_req_o), 32'h1);
      chk("o1_busy", 32'(bus.busy_o), 32'h1);
      tick();
      for (int i = 0; i < 3; i++) begin
         drive(2'b01, 32'h308, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
         chk("o_wait_req", 32'(bus.instr_req_o), 32'h0);
         chk("o_wait_busy", 32'(bus.busy_o), 32'h1);
         tick();
      end
      drive(2'b01, 32'h308, 32'h0, 1'b1, 1'b1, 32'h77, 1'b0);
      chk("o_resp_req", 32'(bus.instr_req_o), 32'h0);
      chk("o_resp_rvalid", 32'(bus.rvalid_o), 32'h1);
      tick();
      drive(2'b01, 32'h308, 32'h0, 1'b1, 1'b1, 32'h88, 1'b0);
      chk("o_third_req", 32'(bus.instr_req_o), 32'h1);
      chk("o_third_addr", bus.instr_addr_o, 32'h308);
      chk("o_third_rvalid", 32'(bus.rvalid_o), 32'h1);
      tick();
      drive(2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 32'h99, 1'b0);
      chk("o_tail_rvalid", 32'(bus.rvalid_o), 32'h1);
      chk("o_tail_busy", 32'(bus.busy_o), 32'h1);
      tick();

      // Error response on port 1, then a spurious response
      drive(2'b10, 32'h0, 32'h900, 1'b1, 1'b0, 32'h0, 1'b0);
      chk("e_gnt", 32'(bus.gnt_o), 32'h2);
      chk("e_addr", bus.instr_addr_o, 32'h900);
      tick();
      drive(2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 32'hDEAD, 1'b1);
      chk("e_rvalid", 32'(bus.rvalid_o), 32'h2);
      chk("e_err", 32'(bus.err_o), 32'h1);
      chk("e_rdata", bus.rdata_o, 32'hDEAD);
      tick();
      drive(2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 32'h1, 1'b0);
      chk("sp_pulse", 32'(bus.spurious_rvalid_o), 32'h1);
      chk("sp_rvalid", 32'(bus.rvalid_o), 32'h0);
      tick();
      drive(2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
      chk("sp_clear", 32'(bus.spurious_rvalid_o), 32'h0);
      chk("sp_busy", 32'(bus.busy_o), 32'h0);

      // Reset while a transaction is outstanding and port 1 is held
      drive(2'b11, 32'h200, 32'h800, 1'b1, 1'b0, 32'h0, 1'b0);
      chk("r_gnt0", 32'(bus.gnt_o), 32'h1);
      tick();
      drive(2'b11, 32'h200, 32'h800, 1'b0, 1'b0, 32'h0, 1'b0);
      chk("r_hold_addr", bus.instr_addr_o, 32'h800);
      tick();
      chk("r_hold_busy", 32'(bus.busy_o), 32'h1);
      rst = 1'b1;
      drive(2'b11, 32'h200, 32'h800, 1'b1, 1'b1, 32'h3, 1'b0);
      chk("r_in_req", 32'(bus.instr_req_o), 32'h0);
      chk("r_in_rvalid", 32'(bus.rvalid_o), 32'h0);
      chk("r_in_spurious", 32'(bus.spurious_rvalid_o), 32'h0);
      tick();
      rst = 1'b0;
      drive(2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
      chk("r_after_req", 32'(bus.instr_req_o), 32'h0);
      chk("r_after_busy", 32'(bus.busy_o), 32'h0);
      drive(2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 32'h4, 1'b0);
      chk("r_late_spurious", 32'(bus.spurious_rvalid_o), 32'h1);
      chk("r_late_rvalid", 32'(bus.rvalid_o), 32'h0);
      tick();
      drive(2'b11, 32'h200, 32'h800, 1'b1, 1'b0, 32'h0, 1'b0);
      chk("r_rr_gnt", 32'(bus.gnt_o), 32'h1);
      chk("r_rr_addr", bus.instr_addr_o, 32'h200);
      tick();
      drive(2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
